// File: rtl/fetch_unit_if.sv
// Memory-side and decoder-side bundles for the instruction fetch unit.
interface fetch_mem_if #(
    parameter int ADDR_W = 10
);
    logic              mem_en;
    logic              mem_burst_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_di;
    logic              mem_ack;
    logic [31:0]       mem_do;

    modport master (
        output mem_en,
        output mem_burst_en,
        output mem_addr,
        output mem_we,
        output mem_di,
        input  mem_ack,
        input  mem_do
    );

    modport slave (
        input  mem_en,
        input  mem_burst_en,
        input  mem_addr,
        input  mem_we,
        input  mem_di,
        output mem_ack,
        output mem_do
    );
endinterface

interface fetch_dec_if #(
    parameter int ADDR_W = 10
);
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;

    modport master (
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Sequential instruction fetcher with prefetch FIFO and redirect flush.
// Define FETCH_BURST_EN to keep mem_en high across consecutive acks.
module fetch_unit #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 10,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    fetch_mem_if.master       mem,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    fetch_dec_if.master       dec
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH  = CW'(DEPTH - 1);

`ifdef FETCH_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_q, fetch_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic              flush_q, flush_d;
    logic              burst_q, burst_d;
    logic [31:0]       data_q [DEPTH];
    logic [31:0]       data_d [DEPTH];
    logic [ADDR_W-1:0] pc_q [DEPTH];
    logic [ADDR_W-1:0] pc_d [DEPTH];

    logic          valid;
    logic          push;
    logic          pop;
    logic [CW-1:0] free_d;

    assign valid = (count_q != '0);

    always_comb begin
        push    = mem.mem_ack && (state_q != FLUSH)
                  && (count_q < DEPTH_C) && !redirect;
        pop     = valid && dec.instr_ready && !redirect;
        state_d = state_q;
        fetch_d = fetch_q;
        count_d = count_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        flush_d = flush_q;
        data_d  = data_q;
        pc_d    = pc_q;

        if (redirect) begin
            state_d = FLUSH;
            fetch_d = redirect_addr;
            count_d = '0;
            wptr_d  = '0;
            rptr_d  = '0;
            flush_d = 1'b1;
        end else begin
            if (push) begin
                data_d[wptr_q] = mem.mem_do;
                pc_d[wptr_q]   = fetch_q;
                wptr_d         = wptr_q + PW'(1);
                fetch_d        = fetch_q + ADDR_W'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);

            // Stop requesting one entry early so a late ack still has a slot.
            unique case (state_q)
                IDLE: begin
                    if (count_d < THRESH) state_d = REQ;
                end
                REQ: begin
                    if (count_d >= THRESH) state_d = IDLE;
                    else if (push && !BURST) state_d = IDLE;
                end
                FLUSH: begin
                    if (!flush_q) state_d = IDLE;
                    else flush_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end

        free_d  = DEPTH_C - count_d;
        burst_d = BURST && (state_d == REQ) && (free_d >= CW'(3));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            fetch_q <= RESET_PC;
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            flush_q <= 1'b0;
            burst_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            fetch_q <= fetch_d;
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            flush_q <= flush_d;
            burst_q <= burst_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
        end
    end

    assign mem.mem_en       = (state_q == REQ);
    assign mem.mem_burst_en = burst_q;
    assign mem.mem_addr     = fetch_q;
    assign mem.mem_we       = 1'b0;
    assign mem.mem_di       = '0;

    assign dec.instr_valid = valid;
    assign dec.instr       = valid ? data_q[rptr_q] : '0;
    assign dec.instr_pc    = valid ? pc_q[rptr_q] : '0;

endmodule
